// File: rtl/byte_unpack_fifo_if.sv
// Word-in / byte-out handshake bundle for byte_unpack_fifo.
// The master side is the producer of words and the consumer of bytes.
interface byte_unpack_fifo_if #(
  parameter int SRAM_DATA_W = 64
);
  logic [SRAM_DATA_W-1:0] word_in;
  logic                   word_in_valid;
  logic                   word_in_ready;
  logic [7:0]             byte_out;
  logic                   byte_out_valid;
  logic                   byte_out_ready;

  modport master (
    output word_in,
    output word_in_valid,
    output byte_out_ready,
    input  word_in_ready,
    input  byte_out,
    input  byte_out_valid
  );

  modport slave (
    input  word_in,
    input  word_in_valid,
    input  byte_out_ready,
    output word_in_ready,
    output byte_out,
    output byte_out_valid
  );
endinterface

// File: rtl/byte_unpack_fifo.sv
// Buffers wide words in a small FIFO and serialises each one LSB byte first,
// flagging the end of every HANG_LEN-word burst with a one-cycle pulse.
module byte_unpack_fifo #(
  parameter int SRAM_DATA_W       = 64,
  parameter int SRAM_DATA_BYTES   = 8,
  parameter int SRAM_DATA_BYTES_B = 3,
  parameter int HANG_LEN          = 64,
  parameter int HANG_LEN_B        = 6,
  parameter int DEPTH             = 4,
  parameter int DEPTH_B           = 2
) (
  input  logic                 src_clk,
  input  logic                 rst_n,
  byte_unpack_fifo_if.slave    bus,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 burst_done
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [SRAM_DATA_BYTES_B-1:0] LAST_IDX   = SRAM_DATA_BYTES_B'(SRAM_DATA_BYTES - 1);
  localparam logic [HANG_LEN_B-1:0]        LAST_WORD  = HANG_LEN_B'(HANG_LEN - 1);
  localparam logic [DEPTH_B:0]             FULL_COUNT = (DEPTH_B + 1)'(DEPTH);

  logic [SRAM_DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH_B:0]             wr_ptr;
  logic [DEPTH_B:0]             rd_ptr;
  logic [DEPTH_B:0]             occupancy;
  logic [SRAM_DATA_W-1:0]       hold_word;
  logic [SRAM_DATA_BYTES_B-1:0] byte_idx;
  logic [HANG_LEN_B-1:0]        words_sent;
  state_t                       state;
  state_t                       next_state;
  logic                         push;
  logic                         pop;
  logic                         handshake;
  logic                         last_handshake;

  // The extra pointer bit distinguishes a full buffer from an empty one.
  assign occupancy         = wr_ptr - rd_ptr;
  assign fifo_full         = (occupancy == FULL_COUNT);
  assign fifo_empty        = (occupancy == '0);
  assign bus.word_in_ready = !fifo_full;
  assign push              = bus.word_in_valid && !fifo_full;

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    pop            = 1'b0;
    handshake      = 1'b0;
    last_handshake = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        if (bus.byte_out_ready) begin
          handshake = 1'b1;
          if (byte_idx == LAST_IDX) begin
            last_handshake = 1'b1;
            // Reloading on the last byte keeps the byte stream gap-free.
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              next_state = IDLE;
            end
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge src_clk) begin
    if (push) begin
      mem[wr_ptr[DEPTH_B-1:0]] <= bus.word_in;
    end
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_word <= '0;
      byte_idx  <= '0;
    end else if (pop) begin
      hold_word <= mem[rd_ptr[DEPTH_B-1:0]];
      byte_idx  <= '0;
    end else if (last_handshake) begin
      byte_idx  <= '0;
    end else if (handshake) begin
      byte_idx  <= byte_idx + 1'b1;
    end
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      words_sent <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      if (last_handshake) begin
        if (words_sent == LAST_WORD) begin
          words_sent <= '0;
          burst_done <= 1'b1;
        end else begin
          words_sent <= words_sent + 1'b1;
        end
      end
    end
  end

  assign bus.byte_out_valid = (state == SEND);
  assign bus.byte_out       = (state == SEND) ? hold_word[{byte_idx, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_byte_unpack_fifo.sv
// Directed self-checking bench for byte_unpack_fifo: latency, backpressure,
// overflow drop, gap-free reload, burst pulse and mid-word reset.
module tb_byte_unpack_fifo;

  logic src_clk;
  logic rst_n;
  logic fifo_full;
  logic fifo_empty;
  logic burst_done;

  byte_unpack_fifo_if #(.SRAM_DATA_W(64)) bus ();

  byte_unpack_fifo dut (
    .src_clk    (src_clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .burst_done (burst_done)
  );

  int          checks   = 0;
  int          failures = 0;
  int          hs_count = 0;
  int          pulses   = 0;
  int          pulse_at = 0;
  logic [63:0] word_tab [80];
  logic [7:0]  exp_q [$];

  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge src_clk);
    #1;
  endtask

  task automatic queue_word(input logic [63:0] w);
    for (int b = 0; b < 8; b++) begin
      exp_q.push_back(w[b*8 +: 8]);
    end
  endtask

  // When honour_ready is clear the word is presented for one edge whether or not it fits.
  task automatic write_words(input int first, input int n, input bit honour_ready);
    int sent  = 0;
    int guard = 0;
    while (sent < n && guard < 2000) begin
      bus.word_in       = word_tab[first + sent];
      bus.word_in_valid = 1'b1;
      if (!honour_ready || bus.word_in_ready) begin
        sent++;
      end
      tick();
      guard++;
    end
    bus.word_in_valid = 1'b0;
    if (sent < n) begin
      checkOutput("write_timeout", 64'(sent), 64'(n));
    end
  endtask

  task automatic drain(input string tag, input int budget, output int bubbles);
    int         cycles  = 0;
    bit         started = 1'b0;
    logic [7:0] exp_byte;
    bubbles = 0;
    bus.byte_out_ready = 1'b1;
    while (exp_q.size() > 0 && cycles < budget) begin
      if (bus.byte_out_valid) begin
        started  = 1'b1;
        exp_byte = exp_q.pop_front();
        checkOutput({tag, "_byte"}, 64'(bus.byte_out), 64'(exp_byte));
        hs_count++;
      end else if (started) begin
        bubbles++;
      end
      tick();
      cycles++;
      if (burst_done) begin
        pulses++;
        pulse_at = hs_count;
      end
    end
    if (exp_q.size() != 0) begin
      checkOutput({tag, "_timeout"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bub;

    // Byte k of word i is i*8+k+1, so word_tab[0] is 64'h0807060504030201.
    for (int i = 0; i < 80; i++) begin
      for (int k = 0; k < 8; k++) begin
        word_tab[i][k*8 +: 8] = 8'((i * 8 + k + 1) & 255);
      end
    end

    rst_n              = 1'b0;
    bus.word_in        = '0;
    bus.word_in_valid  = 1'b0;
    bus.byte_out_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_valid", 64'(bus.byte_out_valid), 64'd0);
    checkOutput("rst_byte", 64'(bus.byte_out), 64'd0);
    checkOutput("rst_burst", 64'(burst_done), 64'd0);
    checkOutput("rst_empty", 64'(fifo_empty), 64'd1);
    checkOutput("rst_full", 64'(fifo_full), 64'd0);
    checkOutput("rst_ready", 64'(bus.word_in_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Single word: two-cycle latency then 01..08 on consecutive cycles.
    bus.byte_out_ready = 1'b1;
    write_words(0, 1, 1'b0);
    checkOutput("lat_valid_n", 64'(bus.byte_out_valid), 64'd0);
    checkOutput("lat_empty_n", 64'(fifo_empty), 64'd0);
    tick();
    checkOutput("lat_valid_n1", 64'(bus.byte_out_valid), 64'd1);
    for (int k = 0; k < 8; k++) begin
      checkOutput("single_valid", 64'(bus.byte_out_valid), 64'd1);
      checkOutput("single_byte", 64'(bus.byte_out), 64'(k + 1));
      tick();
    end
    checkOutput("single_idle_valid", 64'(bus.byte_out_valid), 64'd0);
    checkOutput("single_idle_empty", 64'(fifo_empty), 64'd1);

    // Backpressure at byte index 3 of word_tab[1] (bytes 09..10).
    write_words(1, 1, 1'b0);
    tick();
    checkOutput("bp_b0", 64'(bus.byte_out), 64'h09);
    tick();
    checkOutput("bp_b1", 64'(bus.byte_out), 64'h0A);
    tick();
    checkOutput("bp_b2", 64'(bus.byte_out), 64'h0B);
    tick();
    checkOutput("bp_b3", 64'(bus.byte_out), 64'h0C);
    bus.byte_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("bp_hold_byte", 64'(bus.byte_out), 64'h0C);
      checkOutput("bp_hold_valid", 64'(bus.byte_out_valid), 64'd1);
    end
    exp_q.push_back(8'h0C);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0E);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h10);
    drain("bp", 50, bub);
    checkOutput("bp_idle_valid", 64'(bus.byte_out_valid), 64'd0);

    // Six words against a stalled output: one held, four buffered, sixth dropped.
    bus.byte_out_ready = 1'b0;
    write_words(2, 6, 1'b0);
    checkOutput("full_flag", 64'(fifo_full), 64'd1);
    checkOutput("full_ready", 64'(bus.word_in_ready), 64'd0);
    checkOutput("full_valid", 64'(bus.byte_out_valid), 64'd1);
    checkOutput("full_first", 64'(bus.byte_out), 64'h11);
    for (int i = 2; i < 7; i++) begin
      queue_word(word_tab[i]);
    end
    drain("full", 100, bub);
    checkOutput("full_bubbles", 64'(bub), 64'd0);
    checkOutput("full_after_valid", 64'(bus.byte_out_valid), 64'd0);
    checkOutput("full_after_empty", 64'(fifo_empty), 64'd1);

    // Three words streamed with ready high: 24 bytes with no gap.
    for (int i = 7; i < 10; i++) begin
      queue_word(word_tab[i]);
    end
    fork
      write_words(7, 3, 1'b1);
      drain("b2b", 100, bub);
    join
    checkOutput("b2b_bubbles", 64'(bub), 64'd0);
    checkOutput("b2b_idle", 64'(bus.byte_out_valid), 64'd0);

    // Reset at byte index 5 with two words still buffered.
    bus.byte_out_ready = 1'b0;
    write_words(10, 3, 1'b0);
    bus.byte_out_ready = 1'b1;
    repeat (5) tick();
    checkOutput("mid_b5", 64'(bus.byte_out), 64'h56);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(bus.byte_out_valid), 64'd0);
    checkOutput("mid_rst_byte", 64'(bus.byte_out), 64'd0);
    checkOutput("mid_rst_empty", 64'(fifo_empty), 64'd1);
    checkOutput("mid_rst_full", 64'(fifo_full), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("mid_post_valid", 64'(bus.byte_out_valid), 64'd0);
    checkOutput("mid_post_empty", 64'(fifo_empty), 64'd1);
    queue_word(word_tab[13]);
    write_words(13, 1, 1'b0);
    drain("mid", 50, bub);
    checkOutput("mid_idle", 64'(bus.byte_out_valid), 64'd0);

    // 64-word burst: exactly one pulse, right after the 512th byte handshake.
    hs_count = 0;
    pulses   = 0;
    pulse_at = 0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 14; i < 78; i++) begin
      queue_word(word_tab[i]);
    end
    fork
      write_words(14, 64, 1'b1);
      drain("burst", 2000, bub);
    join
    checkOutput("burst_bubbles", 64'(bub), 64'd0);
    checkOutput("burst_pulses", 64'(pulses), 64'd1);
    checkOutput("burst_pulse_at", 64'(pulse_at), 64'd512);
    tick();
    checkOutput("burst_one_cycle", 64'(burst_done), 64'd0);
    queue_word(word_tab[78]);
    write_words(78, 1, 1'b0);
    drain("burst65", 50, bub);
    repeat (2) begin
      tick();
      if (burst_done) pulses++;
    end
    checkOutput("burst65_pulses", 64'(pulses), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
